// File: rtl/multi_channel_window_comparator.sv
// Multi-channel, edge-qualified equality comparator for the photonic-switch timing counter.
// Per channel: one-cycle match pulse, on/off gate window, and optional one-shot arming.
module multi_channel_window_comparator #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned NCH   = 4
) (
    input  logic                 counter_clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     count,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH-1:0]       oneshot,
    input  logic [NCH-1:0]       arm,
    input  logic [NCH*WIDTH-1:0] on_val,
    input  logic [NCH*WIDTH-1:0] off_val,
    output logic [NCH-1:0]       match_pulse,
    output logic [NCH-1:0]       gate,
    output logic [NCH-1:0]       armed,
    output logic                 any_pulse
);

    logic [WIDTH-1:0] prev_count;
    logic             prev_valid;
    logic             count_moved;
    logic [NCH-1:0]   new_on;
    logic [NCH-1:0]   new_off;
    logic [NCH-1:0]   q_on;
    logic [NCH-1:0]   gate_next;
    logic [NCH-1:0]   armed_next;

    always_comb begin
        // A stalled counter must not retrigger; the first post-reset sample always counts as new.
        count_moved = !prev_valid || (prev_count != count);
        new_on      = '0;
        new_off     = '0;
        q_on        = '0;
        gate_next   = gate;
        armed_next  = armed;
        for (int unsigned i = 0; i < NCH; i++) begin
            new_on[i]  = count_moved && (count == on_val[i*WIDTH +: WIDTH]);
            new_off[i] = count_moved && (count == off_val[i*WIDTH +: WIDTH]);
            q_on[i]    = new_on[i] && ch_en[i] && (armed[i] || !oneshot[i]);

            // Off outranks on, so on_val == off_val yields a pulse-only channel.
            if (!ch_en[i])
                gate_next[i] = 1'b0;
            else if (new_off[i])
                gate_next[i] = 1'b0;
            else if (q_on[i])
                gate_next[i] = 1'b1;

            if (arm[i])
                armed_next[i] = 1'b1;
            else if (oneshot[i] && q_on[i])
                armed_next[i] = 1'b0;
            else if (!oneshot[i])
                armed_next[i] = 1'b1;
        end
    end

    always_ff @(posedge counter_clk) begin
        if (reset) begin
            prev_count  <= '0;
            prev_valid  <= 1'b0;
            match_pulse <= '0;
            gate        <= '0;
            armed       <= '1;
            any_pulse   <= 1'b0;
        end else begin
            prev_count  <= count;
            prev_valid  <= 1'b1;
            match_pulse <= q_on;
            gate        <= gate_next;
            armed       <= armed_next;
            any_pulse   <= |q_on;
        end
    end

endmodule

// File: tb/tb_multi_channel_window_comparator.sv
// Scoreboard bench for multi_channel_window_comparator: a cycle model queues expected outputs
// per driven cycle; each scenario task pops and compares them, plus scenario-level spot checks.
module tb_multi_channel_window_comparator;

    localparam int unsigned W = 7;
    localparam int unsigned N = 4;

    typedef struct packed {
        logic [N-1:0] p;
        logic [N-1:0] g;
        logic [N-1:0] a;
        logic         any;
    } exp_t;

    logic           counter_clk = 1'b0;
    logic           reset;
    logic [W-1:0]   count;
    logic [N-1:0]   ch_en;
    logic [N-1:0]   oneshot;
    logic [N-1:0]   arm;
    logic [N*W-1:0] on_val;
    logic [N*W-1:0] off_val;
    logic [N-1:0]   match_pulse;
    logic [N-1:0]   gate;
    logic [N-1:0]   armed;
    logic           any_pulse;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];
    exp_t e;

    logic [W-1:0] on_v  [N];
    logic [W-1:0] off_v [N];
    logic [W-1:0] m_prev;
    logic         m_pv;
    logic [N-1:0] m_gate;
    logic [N-1:0] m_armed;

    multi_channel_window_comparator #(.WIDTH(W), .NCH(N)) dut (
        .counter_clk (counter_clk),
        .reset       (reset),
        .count       (count),
        .ch_en       (ch_en),
        .oneshot     (oneshot),
        .arm         (arm),
        .on_val      (on_val),
        .off_val     (off_val),
        .match_pulse (match_pulse),
        .gate        (gate),
        .armed       (armed),
        .any_pulse   (any_pulse)
    );

    always #5 counter_clk = ~counter_clk;

    function automatic exp_t obs();
        exp_t o;
        o.p   = match_pulse;
        o.g   = gate;
        o.a   = armed;
        o.any = any_pulse;
        return o;
    endfunction

    // Drive one cycle, push the model's expectation, and return #1 after the edge.
    task automatic apply(input int c, input logic [N-1:0] en, input logic [N-1:0] arm_s, input logic rst);
        exp_t x;
        logic hit_on, hit_off, q;
        count  = W'(c);
        ch_en  = en;
        arm    = arm_s;
        reset  = rst;
        for (int i = 0; i < N; i++) begin
            on_val[i*W +: W]  = on_v[i];
            off_val[i*W +: W] = off_v[i];
        end
        x = '0;
        if (rst) begin
            m_pv    = 1'b0;
            m_gate  = '0;
            m_armed = '1;
        end else begin
            for (int i = 0; i < N; i++) begin
                hit_on  = (count == on_v[i])  && (!m_pv || m_prev != count);
                hit_off = (count == off_v[i]) && (!m_pv || m_prev != count);
                q       = hit_on && en[i] && (m_armed[i] || !oneshot[i]);
                x.p[i]  = q;
                if (!en[i] || hit_off) m_gate[i] = 1'b0;
                else if (q)            m_gate[i] = 1'b1;
                if (arm_s[i])               m_armed[i] = 1'b1;
                else if (oneshot[i] && q)   m_armed[i] = 1'b0;
                else if (!oneshot[i])       m_armed[i] = 1'b1;
            end
            m_pv   = 1'b1;
            m_prev = count;
        end
        x.g   = m_gate;
        x.a   = m_armed;
        x.any = |x.p;
        sb.push_back(x);
        @(posedge counter_clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            apply(0, '1, '0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL reset_sb got=%h want=%h", obs(), e);
            end
        end
        checks++;
        if ({match_pulse, gate, armed, any_pulse} !== {4'h0, 4'h0, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got p=%b g=%b a=%b any=%b want p=0000 g=0000 a=1111 any=0",
                     match_pulse, gate, armed, any_pulse);
        end
    endtask

    task automatic test_sweep();
        int p0, g0, p2, g1;
        p0 = 0; g0 = 0; p2 = 0;
        for (int c = 0; c < 128; c++) begin
            apply(c, '1, '0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL sweep1 c=%0d got=%h want=%h", c, obs(), e);
            end
            p0 += int'(match_pulse[0]);
            g0 += int'(gate[0]);
            p2 += int'(match_pulse[2]);
            checks++;
            if (any_pulse !== (|match_pulse)) begin
                failures++;
                $display("FAIL any_track c=%0d got=%b want=%b", c, any_pulse, |match_pulse);
            end
        end
        checks++;
        if (p0 != 1 || g0 != 10) begin
            failures++;
            $display("FAIL single_match pulses=%0d gate_cycles=%0d want 1 and 10", p0, g0);
        end
        checks++;
        if (p2 != 1 || armed[2] !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_p1 pulses=%0d armed=%b want 1 and 0", p2, armed[2]);
        end
        p2 = 0; g1 = 0;
        for (int c = 0; c < 128; c++) begin
            apply(c, '1, (c == 50) ? 4'b0100 : 4'b0000, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL sweep2 c=%0d got=%h want=%h", c, obs(), e);
            end
            p2 += int'(match_pulse[2]);
            g1 += int'(gate[1]);
        end
        checks++;
        if (g1 != 13) begin
            failures++;
            $display("FAIL wrap_window gate1_cycles=%0d want 13", g1);
        end
        checks++;
        if (p2 != 0 || armed[2] !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_p2 pulses=%0d armed=%b want 0 and 1", p2, armed[2]);
        end
        p2 = 0;
        for (int c = 0; c < 6; c++) begin
            apply(c, '1, '0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL sweep3 c=%0d got=%h want=%h", c, obs(), e);
            end
            p2 += int'(match_pulse[2]);
        end
        checks++;
        if (p2 != 1 || armed[2] !== 1'b0) begin
            failures++;
            $display("FAIL rearm pulses=%0d armed=%b want 1 and 0", p2, armed[2]);
        end
    endtask

    task automatic test_arm_and_match();
        int seq  [5] = '{1, 2, 3, 4, 3};
        int arms [5] = '{1, 0, 1, 0, 0};
        for (int k = 0; k < 5; k++) begin
            apply(seq[k], '1, arms[k] != 0 ? 4'b0100 : 4'b0000, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL arm_match_sb k=%0d got=%h want=%h", k, obs(), e);
            end
            if (k == 2) begin
                checks++;
                if (match_pulse[2] !== 1'b1 || armed[2] !== 1'b1) begin
                    failures++;
                    $display("FAIL arm_with_match pulse=%b armed=%b want 1 and 1", match_pulse[2], armed[2]);
                end
            end
            if (k == 4) begin
                checks++;
                if (match_pulse[2] !== 1'b1 || armed[2] !== 1'b0) begin
                    failures++;
                    $display("FAIL oneshot_consume pulse=%b armed=%b want 1 and 0", match_pulse[2], armed[2]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int seq [8] = '{8, 9, 10, 10, 10, 10, 10, 11};
        int p0, g0;
        p0 = 0; g0 = 0;
        for (int k = 0; k < 8; k++) begin
            apply(seq[k], '1, '0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL stall_sb k=%0d got=%h want=%h", k, obs(), e);
            end
            p0 += int'(match_pulse[0]);
            if (k >= 2 && k <= 6) g0 += int'(gate[0]);
        end
        checks++;
        if (p0 != 1 || g0 != 5) begin
            failures++;
            $display("FAIL stall pulses=%0d gate_hold=%0d want 1 and 5", p0, g0);
        end
    endtask

    task automatic test_enable();
        int seq [18] = '{6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 9, 10, 11, 12, 13, 14, 15};
        int p3, g3, p0d, g0d;
        logic [N-1:0] en;
        p3 = 0; g3 = 0; p0d = 0; g0d = 0;
        for (int k = 0; k < 18; k++) begin
            en = (k >= 9 && k <= 13) ? 4'b1110 : 4'b1111;
            apply(seq[k], en, '0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL enable_sb k=%0d got=%h want=%h", k, obs(), e);
            end
            if (k <= 2) begin
                p3 += int'(match_pulse[3]);
                g3 += int'(gate[3]);
            end
            if (k >= 9) begin
                p0d += int'(match_pulse[0]);
                g0d += int'(gate[0]);
            end
        end
        checks++;
        if (p3 != 1 || g3 != 0) begin
            failures++;
            $display("FAIL equal_vals pulses=%0d gate_cycles=%0d want 1 and 0", p3, g3);
        end
        checks++;
        if (p0d != 0 || g0d != 0) begin
            failures++;
            $display("FAIL disable pulses=%0d gate_cycles=%0d want 0 and 0", p0d, g0d);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 8; c <= 15; c++) begin
            apply(c, '1, '0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL rmid_sb c=%0d got=%h want=%h", c, obs(), e);
            end
        end
        checks++;
        if (gate[0] !== 1'b1) begin
            failures++;
            $display("FAIL rmid_pre gate0=%b want 1", gate[0]);
        end
        apply(15, '1, '0, 1'b1);
        e = sb.pop_front();
        checks++;
        if ({match_pulse, gate, armed, any_pulse} !== {4'h0, 4'h0, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL rmid_reset got p=%b g=%b a=%b any=%b want p=0000 g=0000 a=1111 any=0",
                     match_pulse, gate, armed, any_pulse);
        end
        apply(10, '1, '0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (obs() !== e || match_pulse[0] !== 1'b1) begin
            failures++;
            $display("FAIL rmid_first got=%h want=%h", obs(), e);
        end
    endtask

    initial begin
        on_v[0] = 7'd10;  off_v[0] = 7'd20;
        on_v[1] = 7'd120; off_v[1] = 7'd5;
        on_v[2] = 7'd3;   off_v[2] = 7'd60;
        on_v[3] = 7'd7;   off_v[3] = 7'd7;
        oneshot = 4'b0100;
        m_prev  = '0;
        m_pv    = 1'b0;
        m_gate  = '0;
        m_armed = '1;
        test_reset();
        test_sweep();
        test_arm_and_match();
        test_stall();
        test_enable();
        test_reset_mid();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover size=%0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
